// File: rtl/cc_frame_loader_if.sv
// cc_frame_loader_if
//   Bundles the loader's upstream beat handshake, the registered buses
//   presented to the combinational CC stage, CC's result, and the
//   downstream result handshake.
//   Modports:
//     slave  - the loader itself (cc_frame_loader).
//     master - the surrounding environment: the upstream source, the CC
//              stage (drives cc_out_n) and the downstream sink.
//   Signals:
//     in_valid/in_ready/in_data/in_opt/in_equ  upstream beat handshake
//     cc_in_n0..cc_in_n5, cc_opt, cc_equ        registered operands to CC
//     cc_out_n                                  CC result (10-bit signed)
//     out_valid/out_ready/out_data              result handshake
//     frame_err                                 partial-frame discard pulse
interface cc_frame_loader_if;
  logic              in_valid;
  logic              in_ready;
  logic        [3:0] in_data;
  logic        [2:0] in_opt;
  logic              in_equ;

  logic        [3:0] cc_in_n0;
  logic        [3:0] cc_in_n1;
  logic        [3:0] cc_in_n2;
  logic        [3:0] cc_in_n3;
  logic        [3:0] cc_in_n4;
  logic        [3:0] cc_in_n5;
  logic        [2:0] cc_opt;
  logic              cc_equ;
  logic signed [9:0] cc_out_n;

  logic              out_valid;
  logic              out_ready;
  logic signed [9:0] out_data;

  logic              frame_err;

  modport slave (
    input  in_valid, in_data, in_opt, in_equ, cc_out_n, out_ready,
    output in_ready, cc_in_n0, cc_in_n1, cc_in_n2, cc_in_n3, cc_in_n4,
           cc_in_n5, cc_opt, cc_equ, out_valid, out_data, frame_err
  );

  modport master (
    output in_valid, in_data, in_opt, in_equ, cc_out_n, out_ready,
    input  in_ready, cc_in_n0, cc_in_n1, cc_in_n2, cc_in_n3, cc_in_n4,
           cc_in_n5, cc_opt, cc_equ, out_valid, out_data, frame_err
  );
endinterface

// File: rtl/cc_frame_loader.sv
// cc_frame_loader
//   Sequential front/back-end for the combinational CC sort-and-compute
//   stage. Collects six 4-bit operand beats (opt/equ taken from the first
//   beat), presents them to CC as registered buses, captures CC's 10-bit
//   signed result after one evaluation cycle and holds it under a
//   valid/ready handshake until consumed.
//   Parameters:
//     TIMEOUT_CYC - max consecutive idle LOAD cycles before a partial frame
//                   is dropped (1..255); only used with the macro below.
//   Ports:
//     clk - rising-edge clock
//     rst - synchronous, active-high reset
//     bus - cc_frame_loader_if.slave (beat in, CC buses, result out,
//           frame_err)
//   Build option:
//     CC_LOADER_TIMEOUT_EN - enables the LOAD gap counter and frame_err.
//     Undefined: LOAD waits indefinitely and frame_err is tied 0.
module cc_frame_loader #(
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic               clk,
  input  logic               rst,
  cc_frame_loader_if.slave   bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_EVAL = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("cc_frame_loader: TIMEOUT_CYC must be in 1..255");
  end

  logic [1:0]        state_q, state_d;
  logic [2:0]        count_q, count_d;
  logic [3:0]        slot_q [6];
  logic [3:0]        slot_d [6];
  logic [2:0]        opt_q, opt_d;
  logic              equ_q, equ_d;
  logic              out_valid_q, out_valid_d;
  logic signed [9:0] out_data_q, out_data_d;

  logic              in_ready;
  logic              accept;
  logic              timeout_hit;

  // A timeout cycle refuses beats so that the discard always wins.
  assign in_ready = ((state_q == ST_IDLE) || (state_q == ST_LOAD)) && !timeout_hit;
  assign accept   = bus.in_valid && in_ready;

`ifdef CC_LOADER_TIMEOUT_EN
  localparam logic [7:0] GAP_LIMIT = 8'(TIMEOUT_CYC);

  logic [7:0] gap_q, gap_d;

  // The counter holds GAP_LIMIT for exactly one LOAD cycle; that cycle is
  // the timeout cycle, and frame_err is high only then.
  assign timeout_hit = (state_q == ST_LOAD) && (gap_q == GAP_LIMIT);

  always_comb begin
    gap_d = gap_q;
    if ((state_q != ST_LOAD) || timeout_hit || accept) begin
      gap_d = '0;
    end else begin
      gap_d = gap_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gap_q <= '0;
    end else begin
      gap_q <= gap_d;
    end
  end

  assign bus.frame_err = timeout_hit;
`else
  assign timeout_hit   = 1'b0;
  assign bus.frame_err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    opt_d       = opt_q;
    equ_d       = equ_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    for (int unsigned k = 0; k < 6; k++) begin
      slot_d[k] = slot_q[k];
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          slot_d[0] = bus.in_data;
          opt_d     = bus.in_opt;
          equ_d     = bus.in_equ;
          count_d   = 3'd1;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (timeout_hit) begin
          // Slots deliberately keep their stale contents.
          count_d = '0;
          state_d = ST_IDLE;
        end else if (accept) begin
          for (int unsigned k = 1; k < 6; k++) begin
            if (count_q == 3'(k)) begin
              slot_d[k] = bus.in_data;
            end
          end
          if (count_q == 3'd5) begin
            // Count is not needed past the last slot; park it at 0.
            count_d = '0;
            state_d = ST_EVAL;
          end else begin
            count_d = count_q + 3'd1;
          end
        end
      end
      ST_EVAL: begin
        out_data_d  = bus.cc_out_n;
        out_valid_d = 1'b1;
        state_d     = ST_HOLD;
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      opt_q       <= '0;
      equ_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int unsigned k = 0; k < 6; k++) begin
        slot_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      opt_q       <= opt_d;
      equ_q       <= equ_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      for (int unsigned k = 0; k < 6; k++) begin
        slot_q[k] <= slot_d[k];
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.cc_in_n0  = slot_q[0];
  assign bus.cc_in_n1  = slot_q[1];
  assign bus.cc_in_n2  = slot_q[2];
  assign bus.cc_in_n3  = slot_q[3];
  assign bus.cc_in_n4  = slot_q[4];
  assign bus.cc_in_n5  = slot_q[5];
  assign bus.cc_opt    = opt_q;
  assign bus.cc_equ    = equ_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

endmodule
